// File: rtl/if_id_pipe_stage.sv
// IF/ID elastic pipeline stage: valid/ready handshake, 2-entry skid buffer, flush-to-bubble.
// Optional perf counters (stall_cnt, flush_cnt) enabled by defining IFID_PERF_CNT_EN.
module if_id_pipe_stage #(
  parameter int unsigned PC_W         = 64,
  parameter int unsigned INSTR_W      = 32,
  parameter logic [31:0] BUBBLE_INSTR = 32'h00000013,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  localparam logic [INSTR_W-1:0] BUBBLE = INSTR_W'(BUBBLE_INSTR);

  if (PC_W < 1 || INSTR_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("if_id_pipe_stage: PC_W, INSTR_W and CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t               state_q, state_n;
  logic [PC_W-1:0]    main_pc_q, main_pc_n;
  logic [INSTR_W-1:0] main_instr_q, main_instr_n;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_n;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_n;
  logic               acc, deq;

  assign out_valid = (state_q != EMPTY);
  assign out_pc    = main_pc_q;
  assign out_instr = main_instr_q;
  assign acc       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  always_comb begin
    state_n      = state_q;
    main_pc_n    = main_pc_q;
    main_instr_n = main_instr_q;
    skid_pc_n    = skid_pc_q;
    skid_instr_n = skid_instr_q;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          state_n      = ONE;
          main_pc_n    = in_pc;
          main_instr_n = in_instr;
        end
      end
      ONE: begin
        if (acc && deq) begin
          main_pc_n    = in_pc;
          main_instr_n = in_instr;
        end else if (acc) begin
          state_n      = FULL;
          skid_pc_n    = in_pc;
          skid_instr_n = in_instr;
        end else if (deq) begin
          // Main drains to the bubble so out_* are defined whenever invalid.
          state_n      = EMPTY;
          main_pc_n    = '0;
          main_instr_n = BUBBLE;
        end
      end
      FULL: begin
        if (deq) begin
          state_n      = ONE;
          main_pc_n    = skid_pc_q;
          main_instr_n = skid_instr_q;
        end
      end
      default: begin
        state_n      = EMPTY;
        main_pc_n    = '0;
        main_instr_n = BUBBLE;
      end
    endcase
  end

  // in_ready is computed from the next occupancy and registered, so it never
  // depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q      <= EMPTY;
      in_ready     <= 1'b1;
      main_pc_q    <= '0;
      main_instr_q <= BUBBLE;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_n;
      in_ready     <= (state_n != FULL);
      main_pc_q    <= main_pc_n;
      main_instr_q <= main_instr_n;
      skid_pc_q    <= skid_pc_n;
      skid_instr_q <= skid_instr_n;
    end
  end

`ifdef IFID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Self-checking bench for if_id_pipe_stage: scoreboard monitor plus scenario tasks.
// Perf-counter scenario runs only when IFID_PERF_CNT_EN is defined.
module tb_if_id_pipe_stage;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] BUB     = 32'h00000013;

  logic               clk = 1'b0;
  logic               reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [PC_W-1:0]    in_pc, out_pc;
  logic [INSTR_W-1:0] in_instr, out_instr;
`ifdef IFID_PERF_CNT_EN
  logic [1:0]         stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ent_t;
  ent_t sb[$];

  always #5 clk = ~clk;

  if_id_pipe_stage #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .BUBBLE_INSTR(BUB), .CNT_W(2)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
`ifdef IFID_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // Scoreboard: checks the state left by the last edge, then models the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (out_valid !== (sb.size() != 0)) begin
        errors++;
        $display("FAIL mon_out_valid t=%0t got %b want %b", $time, out_valid, sb.size() != 0);
      end
      checks++;
      if (in_ready !== (sb.size() < 2)) begin
        errors++;
        $display("FAIL mon_in_ready t=%0t got %b want %b", $time, in_ready, sb.size() < 2);
      end
      if (sb.size() == 0) begin
        checks++;
        if (out_pc !== '0 || out_instr !== BUB) begin
          errors++;
          $display("FAIL mon_bubble t=%0t got pc=%h instr=%h want pc=0 instr=%h",
                   $time, out_pc, out_instr, BUB);
        end
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        ent_t e;
        e = sb.pop_front();
        checks++;
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          errors++;
          $display("FAIL mon_order t=%0t got pc=%h instr=%h want pc=%h instr=%h",
                   $time, out_pc, out_instr, e.pc, e.instr);
        end
      end
      if (reset || flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back('{pc: in_pc, instr: in_instr});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h1000; in_instr = 32'h0000_1234;
    tick();
    mon_en = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_instr !== BUB || out_pc !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_vals got v=%b instr=%h pc=%h rdy=%b want v=0 instr=%h pc=0 rdy=1",
               out_valid, out_instr, out_pc, in_ready, BUB);
    end
    reset = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h1000 || out_instr !== 32'h0000_1234) begin
      errors++;
      $display("FAIL reset_first_acc got v=%b pc=%h instr=%h want v=1 pc=1000 instr=00001234",
               out_valid, out_pc, out_instr);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 64'(4 * i); in_instr = 32'(32'hA + i);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4 * i) || out_instr !== 32'(32'hA + i)
          || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d got v=%b pc=%h instr=%h rdy=%b want v=1 pc=%h instr=%h rdy=1",
                 i, out_valid, out_pc, out_instr, in_ready, 4 * i, 32'hA + i);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h10; in_instr = 32'h110;
    tick();
    in_pc = 64'h14; in_instr = 32'h114;
    tick();
    in_pc = 64'h18; in_instr = 32'h118;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_pc !== 64'h10 || out_instr !== 32'h110) begin
        errors++;
        $display("FAIL stall_hold_%0d got rdy=%b pc=%h instr=%h want rdy=0 pc=10 instr=110",
                 i, in_ready, out_pc, out_instr);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_pc !== 64'h14 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_rel1 got pc=%h rdy=%b want pc=14 rdy=1", out_pc, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_pc !== 64'h18 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_rel2 got pc=%h v=%b want pc=18 v=1", out_pc, out_valid);
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h30; in_instr = 32'h130;
    tick();
    in_pc = 64'h34; in_instr = 32'h134;
    tick();
    flush = 1'b1; in_pc = 64'h20; in_instr = 32'h120;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== BUB || out_pc !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full got v=%b instr=%h pc=%h rdy=%b want v=0 instr=%h pc=0 rdy=1",
               out_valid, out_instr, out_pc, in_ready, BUB);
    end
    tick();
    // Flush in ONE with a same-edge accept: the accepted entry must be discarded.
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h40; in_instr = 32'h140;
    tick();
    flush = 1'b1; in_pc = 64'h44; in_instr = 32'h144;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_acc got v=%b pc=%h rdy=%b want v=0 pc=0 rdy=1",
               out_valid, out_pc, in_ready);
    end
    tick();
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h50; in_instr = 32'h150;
    tick();
    reset = 1'b1; flush = 1'b1; in_pc = 64'h54; in_instr = 32'h154;
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== BUB || out_pc !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_flush_acc got v=%b instr=%h pc=%h rdy=%b want v=0 instr=%h pc=0 rdy=1",
               out_valid, out_instr, out_pc, in_ready, BUB);
    end
    in_valid = 1'b1; in_pc = 64'h60; in_instr = 32'h160;
    tick();
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== '0) begin
      errors++;
      $display("FAIL flush_deq got v=%b pc=%h want v=0 pc=0", out_valid, out_pc);
    end
    // Reset mid-stall drops both held entries.
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h70; in_instr = 32'h170;
    tick();
    in_pc = 64'h74; in_instr = 32'h174;
    tick();
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== BUB) begin
      errors++;
      $display("FAIL reset_full got v=%b rdy=%b instr=%h want v=0 rdy=1 instr=%h",
               out_valid, in_ready, out_instr, BUB);
    end
    tick();
  endtask

`ifdef IFID_PERF_CNT_EN
  task automatic test_perf();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (stall_cnt !== 2'd0 || flush_cnt !== 2'd0) begin
      errors++;
      $display("FAIL perf_reset got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h80; in_instr = 32'h180;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (stall_cnt !== 2'd2) begin
      errors++;
      $display("FAIL perf_stall2 got %0d want 2", stall_cnt);
    end
    tick(); tick(); tick();
    checks++;
    if (stall_cnt !== 2'd3) begin
      errors++;
      $display("FAIL perf_stall_sat got %0d want 3", stall_cnt);
    end
    flush = 1'b1;
    tick(); tick();
    flush = 1'b0;
    checks++;
    if (flush_cnt !== 2'd2 || stall_cnt !== 2'd3) begin
      errors++;
      $display("FAIL perf_flush got flush=%0d stall=%0d want 2 3", flush_cnt, stall_cnt);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (stall_cnt !== 2'd0 || flush_cnt !== 2'd0) begin
      errors++;
      $display("FAIL perf_clear got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
    end
    out_ready = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_reset_flush();
`ifdef IFID_PERF_CNT_EN
    test_perf();
`endif
    tick();
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
